// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES round-function pipeline stage:
//   HALF_W / EXP_W : 32-bit half-block and 48-bit expanded-block widths
//   SBOX           : the eight DES S-boxes, 4 rows x 16 columns of 4 bits
//   P_TABLE        : the 32-bit P permutation (1-based DES bit numbers)
// All vectors in this block are declared ascending ([0:N-1]) so that index 0
// is the MSB and matches DES bit 1.
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int HALF_W   = 32;
  localparam int EXP_W    = 48;
  localparam int NUM_SBOX = 8;

  // One S-box row: 16 nibbles, column 0 sits in the top nibble ([15]).
  typedef logic [15:0][3:0] sbox_row_t;

  localparam sbox_row_t SBOX [NUM_SBOX][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},   // S1
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},   // S2
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},   // S3
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},   // S4
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},   // S5
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},   // S6
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},   // S7
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}    // S8
  };

  // P: output bit j (DES bit j+1) takes S-output DES bit P_TABLE[j].
  localparam int P_TABLE [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_sbox_stage_if.sv
// -----------------------------------------------------------------------------
// des_sbox_stage_if
// Valid/ready bus around the DES f-function stage.
//   in_valid/in_ready   : input beat handshake
//   in_exp, in_key      : 48-bit E(R) and round subkey
//   in_l                : 32-bit left half
//   out_valid/out_ready : output beat handshake
//   out_data            : 32-bit L xor P(S(E(R) xor K))
// master = producer/consumer side (drives inputs), slave = the stage.
// -----------------------------------------------------------------------------
interface des_sbox_stage_if;
  import des_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [0:EXP_W-1]    in_exp;
  logic [0:EXP_W-1]    in_key;
  logic [0:HALF_W-1]   in_l;
  logic                out_valid;
  logic                out_ready;
  logic [0:HALF_W-1]   out_data;

  modport master (
    output in_valid, in_exp, in_key, in_l, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_exp, in_key, in_l, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/des_sbox.sv
// -----------------------------------------------------------------------------
// des_sbox
// Combinational lookup into one DES S-box.
//   IDX  : which S-box (0 = S1 ... 7 = S8)
//   din  : 6-bit group, din[5] = first (most significant) DES bit of the group
//   dout : 4-bit S-box output, dout[3] = MSB
// Row is formed from the outer bits {din[5], din[0]}, column from din[4:1].
// -----------------------------------------------------------------------------
module des_sbox
  import des_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [5:0] din,
  output logic [3:0] dout
);

  logic [1:0] row;
  logic [3:0] col;
  sbox_row_t  row_bits;

  assign row      = {din[5], din[0]};
  assign col      = din[4:1];
  assign row_bits = SBOX[IDX][row];
  // Column 0 is stored in the top nibble, so the column index is reversed.
  assign dout     = row_bits[4'd15 - col];

endmodule

// File: rtl/des_sbox_stage.sv
// -----------------------------------------------------------------------------
// des_sbox_stage
// Two-stage valid/ready pipeline computing the DES round output
//   out_data = L xor P(S(E(R) xor K))
// Stage 1 registers x = in_exp xor in_key and L; stage 2 registers the
// S-box/P result xor L. Each stage advances when it is empty or the stage
// after it advances, so a full pipeline with out_ready high streams one beat
// per cycle and a stalled pipeline holds its contents.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : des_sbox_stage_if.slave (input and output handshakes + data)
// -----------------------------------------------------------------------------
module des_sbox_stage
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  des_sbox_stage_if.slave      bus
);

  logic                v1;
  logic                v2;
  logic                adv1;
  logic                adv2;
  logic [0:EXP_W-1]    x_q;
  logic [0:HALF_W-1]   l_q;
  logic [0:HALF_W-1]   s_out;
  logic [0:HALF_W-1]   p_out;
  logic [0:HALF_W-1]   data_q;

  // Backpressure chain: purely from state and out_ready, never from in_valid.
  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = adv1;

  // Stage 1: key mixing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      v1  <= 1'b0;
      // NOTE: the datapath registers are reset as well, so out_data reads
      // zero after reset and no X ever reaches the output.
      x_q <= '0;
      l_q <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      // A bubble only clears the valid flag; data is left untouched.
      if (bus.in_valid) begin
        x_q <= bus.in_exp ^ bus.in_key;
        l_q <= bus.in_l;
      end
    end
  end

  // S layer: group i of x (DES bits 6i+1..6i+6) feeds S-box i+1; outputs are
  // concatenated S1..S8 from the MSB down.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    des_sbox #(.IDX(g)) u_sbox (
      .din  (x_q[6*g +: 6]),
      .dout (s_out[4*g +: 4])
    );
  end

  // P layer: fixed wiring.
  for (genvar j = 0; j < HALF_W; j++) begin : g_perm
    assign p_out[j] = s_out[P_TABLE[j] - 1];
  end

  // Stage 2: result register, held while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      data_q <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        data_q <= l_q ^ p_out;
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_des_sbox_stage.sv
// -----------------------------------------------------------------------------
// tb_des_sbox_stage
// Self-checking bench for des_sbox_stage. Holds its own S-box and P tables
// (written out independently of des_pkg) for the reference model, plus
// hand-computed vectors for the fixed cases.
// -----------------------------------------------------------------------------
module tb_des_sbox_stage;

  logic clk = 1'b0;
  logic rst;

  des_sbox_stage_if bus ();

  des_sbox_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // S-boxes, row-major: entry [box][row*16 + col].
  localparam int TB_S [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  localparam int TB_P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  typedef struct {
    logic [0:47] exp_v;
    logic [0:47] key_v;
    logic [0:31] l_v;
    logic [0:31] want;
  } vec_t;

  typedef struct {
    logic [0:31] data;
    int          grp;   // >= 0: S-box sweep beat, check one nibble only
    int          val;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;
  int   checks    = 0;
  int   errors    = 0;
  int   out_count = 0;
  int   drv_grp   = -1;
  int   drv_val   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] tb_nib(input int box, input logic [5:0] six);
    int r;
    int c;
    int v;
    r = int'({six[5], six[0]});
    c = int'(six[4:1]);
    v = TB_S[box][r*16 + c];
    return v[3:0];
  endfunction

  function automatic logic [0:31] ref_s(input logic [0:47] x);
    logic [0:31] s;
    for (int i = 0; i < 8; i++) s[4*i +: 4] = tb_nib(i, x[6*i +: 6]);
    return s;
  endfunction

  function automatic logic [0:31] ref_p(input logic [0:31] s);
    logic [0:31] p;
    for (int j = 0; j < 32; j++) p[j] = s[TB_P[j] - 1];
    return p;
  endfunction

  function automatic logic [0:31] inv_p(input logic [0:31] p);
    logic [0:31] s;
    for (int j = 0; j < 32; j++) s[TB_P[j] - 1] = p[j];
    return s;
  endfunction

  function automatic logic [0:31] model(input logic [0:47] e, input logic [0:47] k,
                                        input logic [0:31] l);
    return l ^ ref_p(ref_s(e ^ k));
  endfunction

  // Scoreboard: record accepted beats, compare emitted beats in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        check("out_has_pending_beat", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          if (cur.grp >= 0)
            check($sformatf("sbox_nibble_g%0d_v%0d", cur.grp, cur.val),
                  64'(inv_p(bus.out_data) >> (4*(7 - cur.grp)) & 32'hF),
                  64'(tb_nib(cur.grp, cur.val[5:0])));
          else
            check("out_order_data", 64'(bus.out_data), 64'(cur.data));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{model(bus.in_exp, bus.in_key, bus.in_l), drv_grp, drv_val});
    end
  end

  // Present one beat (called just after a rising edge); returns once accepted.
  task automatic drive_beat(input logic [0:47] e, input logic [0:47] k,
                            input logic [0:31] l, output int taken);
    logic acc;
    taken = 0;
    acc   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_exp   = e;
    bus.in_key   = k;
    bus.in_l     = l;
    while (!acc && taken < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      taken++;
    end
    check("accept_within_budget", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_beat(output logic [0:47] e, output logic [0:47] k,
                           output logic [0:31] l);
    logic [63:0] t;
    t = {$urandom(), $urandom()}; e = t[47:0];
    t = {$urandom(), $urandom()}; k = t[47:0];
    l = $urandom();
  endtask

  vec_t        vecs [5];
  logic [0:47] re, rk;
  logic [0:31] rl, want_a;
  logic [0:47] se;
  int          taken;
  int          base;

  initial begin
    vecs[0] = '{48'h7A15557A1555, 48'h1B02EFFC7072, 32'hCC00CCFF, 32'hEF4A6544};
    vecs[1] = '{48'h7A15557A1555, 48'h1B02EFFC7072, 32'h00000000, 32'h234AA9BB};
    vecs[2] = '{48'h000000000000, 48'h000000000000, 32'h00000000, 32'hD8D8DBBC};
    vecs[3] = '{48'h123456789ABC, 48'h123456789ABC, 32'h0F0F0F0F, 32'hD7D7D4B3};
    vecs[4] = '{48'hFFFFFFFFFFFF, 48'h000000000000, 32'h00000000, 32'h38DBF9CB};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_key    = '0;
    bus.in_l      = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, one at a time, with 2-cycle latency check.
    for (int i = 0; i < 5; i++) begin
      drive_beat(vecs[i].exp_v, vecs[i].key_v, vecs[i].l_v, taken);
      @(negedge clk);
      check($sformatf("vec%0d_valid_cycle1", i), 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid_cycle2", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].want));
      if (vecs[i].l_v == 32'h0 && vecs[i].exp_v == 48'h7A15557A1555)
        check("fips_s_intermediate", 64'(inv_p(bus.out_data)), 64'h5C82B597);
      @(posedge clk); #1;
    end

    // Back-to-back stream of 16 random beats.
    base = out_count;
    for (int i = 0; i < 16; i++) begin
      rand_beat(re, rk, rl);
      drive_beat(re, rk, rl, taken);
      check("stream_in_ready_held", 64'(taken), 64'd1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("stream_out_count", 64'(out_count - base), 64'd16);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: two beats fill the pipe, the third waits.
    base = out_count;
    bus.out_ready = 1'b0;
    rand_beat(re, rk, rl);
    want_a = model(re, rk, rl);
    drive_beat(re, rk, rl, taken);
    rand_beat(re, rk, rl);
    drive_beat(re, rk, rl, taken);
    rand_beat(re, rk, rl);
    bus.in_valid = 1'b1;
    bus.in_exp   = re;
    bus.in_key   = rk;
    bus.in_l     = rl;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out_data_stable", 64'(bus.out_data), 64'(want_a));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_out_count", 64'(out_count - base), 64'd3);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with both stages valid.
    bus.out_ready = 1'b0;
    rand_beat(re, rk, rl);
    drive_beat(re, rk, rl, taken);
    rand_beat(re, rk, rl);
    drive_beat(re, rk, rl, taken);
    @(negedge clk);
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_out_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale_beat", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Exhaustive S-box sweep, key = 0, L = 0, other groups 0.
    base = out_count;
    for (int g = 0; g < 8; g++) begin
      for (int v = 0; v < 64; v++) begin
        se = '0;
        se[6*g +: 6] = 6'(v);
        drv_grp = g;
        drv_val = v;
        drive_beat(se, 48'h0, 32'h0, taken);
      end
    end
    drv_grp = -1;
    repeat (4) @(posedge clk);
    #1;
    check("sweep_out_count", 64'(out_count - base), 64'd512);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
